i2c_slave_write_burst: RTL
==========================

# i2c_slave_write_burst

Parametrised I2C slave transmitter that shifts a burst of 1..BYTE_MAX bytes onto SDA under master-driven SCL, MSB first per byte. After each byte it samples the master ACK/NACK, and it terminates early on NACK or abort. It sits under the slave protocol FSM in place of the single-byte, bit-serial writer. Data is loaded in parallel, so no per-bit load handshake is needed.

## Interface
Parameters:
- BYTE_MAX, 4: maximum bytes per burst, ≥1.
- CHECK_ACK, 1: 1 = NACK ends burst; 0 = ACK bit ignored, all requested bytes sent.

Ports:
- clock  input  1  system clock, single domain.
- reset_n  input  1  asynchronous, active-low reset.
- go  input  1  start request; sampled only in IDLE.
- byte_count  input  $clog2(BYTE_MAX+1)  bytes to send; captured with go.
- data  input  8*BYTE_MAX  payload; byte k = data[8k+7:8k], byte 0 sent first; captured with go.
- abort  input  1  upper layer cancels burst (bus STOP/START seen).
- scl  input  1  bus clock from pin (asynchronous).
- sda_in  input  1  bus data from pin (asynchronous).
- sda_out  output  1  0 = pull SDA low, 1 = release.
- busy  output  1  high from go acceptance until finish.
- finish  output  1  one-cycle completion pulse.
- nack  output  1  burst ended by master NACK or abort; valid at finish, held until next accepted go.
- bytes_sent  output  $clog2(BYTE_MAX+1)  bytes completed with ACK phase; held until next go.

## Operation
- Reset values: sda_out=1, busy=0, finish=0, nack=0, bytes_sent=0, state IDLE.
- scl and sda_in pass through a 2-flop synchroniser. Edges are detected from the synchronised value and its one-cycle delayed copy.
- States:
  - IDLE: on go, capture data and byte_count (values above BYTE_MAX clamp to BYTE_MAX); clear nack and bytes_sent; assert busy.
    - byte_count=0 → DONE.
    - Otherwise → WAIT_FALL.
  - WAIT_FALL: on SCL fall, drive bit 7 of the current byte → SHIFT; bit counter=7.
  - SHIFT: on each SCL fall, decrement bit counter and drive the next bit. On the fall after bit 0, release sda_out → ACK_RISE.
  - ACK_RISE: on SCL rise, latch ack = synchronised sda_in; bytes_sent+1 → ACK_FALL.
  - ACK_FALL: on SCL fall, branch on the latched ack:
    - ack=1 with CHECK_ACK=1 → nack=1, DONE.
    - Last byte → DONE.
    - Otherwise drive bit 7 of the next byte → SHIFT.
  - DONE: sda_out=1, finish=1 for one cycle, busy=0 → IDLE.
- abort in any non-IDLE state: sda_out=1 next cycle, nack=1, finish pulse, → IDLE. bytes_sent keeps its current value. abort has priority over a same-cycle SCL edge. abort in IDLE is ignored.
- go while busy is ignored. go and abort together in IDLE: go accepted.
- SCL high periods never change sda_out, except for abort/reset release.

## Timing
- sda_out updates 3 clock cycles after an SCL pin edge: 2 synchroniser cycles plus the registered update.
- ACK is sampled from sda_in synchronised with identical latency, so both are aligned to the same SCL rise.
- go accepted → busy high next cycle.
- byte_count=0 → finish on the 2nd cycle after go.
- finish occurs 1 cycle after the ACK_FALL decision edge, or 1 cycle after abort.
- Minimum SCL low/high phase: 4 clock cycles.
- reset_n low mid-burst: all outputs go to reset values immediately (asynchronously), so sda_out releases at once.

## Structure
- Shared package i2c_pkg:
  - state encoding localparams, shared with the other slave/master byte blocks;
  - ACK=1'b0, NACK=1'b1;
  - SDA_RELEASE=1'b1.
- Sub-module i2c_line_sync: 2-flop synchroniser plus rise/fall detection for one line. Instantiated for scl and sda_in; reusable by the master side.
- Shift register is 8 bits, reloaded per byte from a byte index mux. The byte index counter is $clog2(BYTE_MAX) bits.

## Test plan
- BYTE_MAX=4, byte_count=4, data=32'h13_57_9b_df, master ACKs all → bench captures df,9b,57,13 on SCL rises; finish, nack=0, bytes_sent=4.
- Same data, master NACKs byte 1 → only df,9b sent; sda_out=1 from byte 1's ACK phase on; nack=1, bytes_sent=2.
- CHECK_ACK=0, NACK on every byte, byte_count=3 → df,9b,57 sent; nack=0, bytes_sent=3.
- byte_count=0 → finish on 2nd cycle after go, sda_out stays 1; byte_count=7 with BYTE_MAX=4 → clamped, 4 bytes sent.
- abort after 3 bits of byte 1 → sda_out=1 next cycle, finish, nack=1, bytes_sent=1; a second go during busy is ignored.
- reset_n pulsed low mid-byte → sda_out=1 and busy=0 immediately; a new go afterwards sends a full correct burst.

Source files
------------

// File: rtl/i2c_pkg.sv
// Definitions shared by the I2C slave/master byte-level blocks.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitFall = 3'd1,
    StShift    = 3'd2,
    StAckRise  = 3'd3,
    StAckFall  = 3'd4,
    StDone     = 3'd5
  } i2c_state_e;

  localparam logic ACK         = 1'b0;
  localparam logic NACK        = 1'b1;
  localparam logic SDA_RELEASE = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser for one I2C line with rise/fall detection on the synchronised level.
module i2c_line_sync
  import i2c_pkg::*;
#(
  parameter logic ResetVal = SDA_RELEASE
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
      prev_q <= ResetVal;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_slave_write_burst.sv
// I2C slave transmitter: shifts 1..BYTE_MAX parallel-loaded bytes onto SDA, MSB first,
// sampling the master ACK after each byte.
module i2c_slave_write_burst
  import i2c_pkg::*;
#(
  parameter int unsigned  BYTE_MAX  = 4,
  parameter bit           CHECK_ACK = 1'b1,
  localparam int unsigned CntW      = $clog2(BYTE_MAX + 1),
  localparam int unsigned IdxW      = (BYTE_MAX > 1) ? $clog2(BYTE_MAX) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  go_i,
  input  logic [CntW-1:0]       byte_count_i,
  input  logic [8*BYTE_MAX-1:0] data_i,
  input  logic                  abort_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic                  busy_o,
  output logic                  finish_o,
  output logic                  nack_o,
  output logic [CntW-1:0]       bytes_sent_o
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(BYTE_MAX);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;
  logic unused_sync;

  i2c_line_sync #(.ResetVal(1'b1)) u_scl_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .line_i  (scl_i),
    .level_o (scl_level),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_line_sync #(.ResetVal(SDA_RELEASE)) u_sda_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .line_i  (sda_i),
    .level_o (sda_level),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  assign unused_sync = ^{scl_level, sda_rise, sda_fall};

  i2c_state_e                 state_q, state_d;
  logic [BYTE_MAX-1:0][7:0]   data_q, data_d;
  logic [CntW-1:0]            count_q, count_d;
  logic [CntW-1:0]            sent_q, sent_d;
  logic [IdxW-1:0]            idx_q, idx_d, idx_nxt;
  logic [7:0]                 shift_q, shift_d, cur_byte, nxt_byte;
  logic [2:0]                 bit_q, bit_d;
  logic                       sda_q, sda_d, ack_q, ack_d;
  logic                       nack_q, nack_d, busy_q, busy_d, finish_q, finish_d;

  assign idx_nxt  = idx_q + IdxW'(1);
  assign cur_byte = data_q[idx_q];
  assign nxt_byte = data_q[idx_nxt];

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    count_d  = count_q;
    sent_d   = sent_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    sda_d    = sda_q;
    ack_d    = ack_q;
    nack_d   = nack_q;
    busy_d   = busy_q;
    finish_d = 1'b0;
    // Abort wins over any SCL edge seen in the same cycle.
    if (state_q != StIdle && abort_i) begin
      state_d  = StIdle;
      sda_d    = SDA_RELEASE;
      nack_d   = 1'b1;
      finish_d = 1'b1;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (go_i) begin
            data_d  = data_i;
            count_d = (byte_count_i > MaxCnt) ? MaxCnt : byte_count_i;
            idx_d   = '0;
            sent_d  = '0;
            nack_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = (byte_count_i == '0) ? StDone : StWaitFall;
          end
        end
        StWaitFall: begin
          if (scl_fall) begin
            sda_d   = cur_byte[7];
            shift_d = {cur_byte[6:0], 1'b0};
            bit_d   = 3'd7;
            state_d = StShift;
          end
        end
        StShift: begin
          if (scl_fall) begin
            if (bit_q == 3'd0) begin
              sda_d   = SDA_RELEASE;
              state_d = StAckRise;
            end else begin
              sda_d   = shift_q[7];
              shift_d = {shift_q[6:0], 1'b0};
              bit_d   = bit_q - 3'd1;
            end
          end
        end
        StAckRise: begin
          if (scl_rise) begin
            ack_d   = sda_level;
            sent_d  = sent_q + CntW'(1);
            state_d = StAckFall;
          end
        end
        StAckFall: begin
          if (scl_fall) begin
            if (CHECK_ACK && ack_q == NACK) begin
              nack_d  = 1'b1;
              state_d = StDone;
            end else if (sent_q == count_q) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_nxt;
              sda_d   = nxt_byte[7];
              shift_d = {nxt_byte[6:0], 1'b0};
              bit_d   = 3'd7;
              state_d = StShift;
            end
          end
        end
        StDone: begin
          sda_d    = SDA_RELEASE;
          finish_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      data_q   <= '0;
      count_q  <= '0;
      sent_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      sda_q    <= SDA_RELEASE;
      ack_q    <= ACK;
      nack_q   <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      sda_q    <= sda_d;
      ack_q    <= ack_d;
      nack_q   <= nack_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
    end
  end

  assign sda_o        = sda_q;
  assign busy_o       = busy_q;
  assign finish_o     = finish_q;
  assign nack_o       = nack_q;
  assign bytes_sent_o = sent_q;

endmodule
